pipe_stage_skid: RTL and testbench
==================================

// Module: pipe_stage_skid
// PURPOSE
//  Parametrised inter-stage pipeline register with a valid/ready handshake and a 2-entry skid buffer.
//  It carries an opaque payload (decoded instr + control bits) plus a ROB index between stages.
//  It supports whole-stage flush, an external hold (e.g. d-cache stall) and a saturating back-pressure counter.
//  in_ready never depends combinationally on out_ready.
// PARAMETERS
//  DATA_W       128  payload width in bits
//  ROB_IDX_W    4    ROB index width
//  ZERO_PAYLOAD 1    1: reset/flush clear stored payload and ROB idx to 0; 0: payload left stale
//  CNT_W        16   width of back-pressure cycle counter
// PORTS
//  clk            in   1          clock, all state updates on posedge
//  reset          in   1          asynchronous, active-high
//  in_valid       in   1          upstream has an entry
//  in_ready       out  1          stage can accept (in_fire = in_valid & in_ready)
//  in_data        in   DATA_W     upstream payload
//  in_rob_idx     in   ROB_IDX_W  upstream ROB index
//  in_flush       in   1          synchronous kill of all held entries
//  in_stall       in   1          external hold: no accept, no emit
//  out_valid      out  1          head entry presented downstream
//  out_ready      in   1          downstream accepts (out_fire = out_valid & out_ready)
//  out_data       out  DATA_W     head payload (main entry M)
//  out_rob_idx    out  ROB_IDX_W  head ROB index
//  out_occupancy  out  2          number of held entries, 0..2
//  out_stall_cnt  out  CNT_W      saturating count of back-pressure cycles
// BEHAVIOUR
//  Storage: main entry M (drives out_*), skid entry S. State EMPTY / ONE (M valid) / TWO (M and S valid).
//  Async reset: state EMPTY and out_stall_cnt=0 immediately. M, S payload and ROB idx = 0.
//   While reset is high: out_valid=0, in_ready=0, out_occupancy=0.
//  Combinational:
//   in_ready  = !S_valid & !in_stall & !in_flush & !reset
//   out_valid = M_valid & !in_stall & !in_flush
//   out_occupancy = M_valid + S_valid
//  Transitions (posedge, no flush, no stall):
//   EMPTY: in_fire -> ONE, M<=in.
//   ONE: in_fire&out_fire -> ONE, M<=in. in_fire&!out_fire -> TWO, S<=in.
//   ONE: !in_fire&out_fire -> EMPTY. Otherwise hold.
//   TWO: in_ready=0. out_fire -> ONE, M<=S, S invalidated. Otherwise hold.
//  Latency: one cycle from in_fire to out_valid when EMPTY. Full throughput when out_ready stays 1.
//  Ordering is strict FIFO. No entry is lost or duplicated.
//  Flush (priority below reset, above all else): next state EMPTY.
//   The payload in flight on in_* that cycle is not accepted, since in_ready=0.
//   With ZERO_PAYLOAD=1, M/S payload and ROB idx are cleared to 0.
//  Stall: in_stall=1 freezes all state. Flush during stall still empties the stage.
//  Counter: increments when M_valid & !in_flush & (in_stall | !out_ready).
//   It saturates at 2**CNT_W-1. It is cleared only by reset. Flush does not clear it.
//  Reset mid-operation discards all entries. No partial transfer is reported.
// TESTING
//  1 Stream: out_ready=1, push 0xA,0xB,0xC on consecutive cycles
//    -> out_data 0xA,0xB,0xC one cycle later each; occupancy 1; in_ready held 1.
//  2 Backpressure: out_ready=0, push 0x11,0x22 -> occupancy 2, in_ready=0, 0x33 held by source;
//    then out_ready=1 -> outputs 0x11,0x22,0x33 in order, no duplicates.
//  3 Flush at occupancy 2 with in_valid=1, in_data=0x44
//    -> next cycle occupancy 0, out_valid 0, out_data 0 (ZERO_PAYLOAD=1); 0x44 never emitted.
//  4 Stall at occupancy 1, out_ready=1, in_stall high 3 cycles
//    -> out_valid 0, no transfers, stall_cnt +3; release -> entry emitted next cycle.
//  5 Async reset pulse between edges at occupancy 2
//    -> out_valid, out_occupancy, stall_cnt read 0 before the next edge; out_data 0.
//  6 CNT_W=4, occupancy 1, out_ready=0 for 20 cycles -> out_stall_cnt saturates at 15.

Source files
------------

// File: rtl/pipe_stage_skid_if.sv
// pipe_stage_skid_if: upstream/downstream handshake bundle for the skid-buffered pipeline stage
interface pipe_stage_skid_if #(
  parameter int DATA_W    = 128,
  parameter int ROB_IDX_W = 4,
  parameter int CNT_W     = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic [DATA_W-1:0]    in_data;
  logic [ROB_IDX_W-1:0] in_rob_idx;
  logic                 in_flush;
  logic                 in_stall;
  logic                 out_valid;
  logic                 out_ready;
  logic [DATA_W-1:0]    out_data;
  logic [ROB_IDX_W-1:0] out_rob_idx;
  logic [1:0]           out_occupancy;
  logic [CNT_W-1:0]     out_stall_cnt;
  modport slave (
    input  in_valid, in_data, in_rob_idx, in_flush, in_stall, out_ready,
    output in_ready, out_valid, out_data, out_rob_idx, out_occupancy, out_stall_cnt
  );
  modport master (
    output in_valid, in_data, in_rob_idx, in_flush, in_stall, out_ready,
    input  in_ready, out_valid, out_data, out_rob_idx, out_occupancy, out_stall_cnt
  );
endinterface

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready pipeline register with 2-entry skid, flush, hold and back-pressure counter
module pipe_stage_skid #(
  parameter int DATA_W       = 128,
  parameter int ROB_IDX_W    = 4,
  parameter bit ZERO_PAYLOAD = 1'b1,
  parameter int CNT_W        = 16
) (
  input logic            clk,
  input logic            reset,
  pipe_stage_skid_if.slave bus
);
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  state_t               state_q, state_d;
  logic [DATA_W-1:0]    m_data_q, m_data_d, s_data_q, s_data_d;
  logic [ROB_IDX_W-1:0] m_rob_q, m_rob_d, s_rob_q, s_rob_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 m_valid, s_valid, in_fire, out_fire, clr, m_take_in, m_take_s, s_take_in;
  // in_ready is derived from local state only, never from out_ready
  always_comb begin
    m_valid   = state_q != EMPTY;
    s_valid   = state_q == TWO;
    bus.in_ready      = !s_valid && !bus.in_stall && !bus.in_flush && !reset;
    bus.out_valid     = m_valid && !bus.in_stall && !bus.in_flush;
    bus.out_data      = m_data_q;
    bus.out_rob_idx   = m_rob_q;
    bus.out_occupancy = 2'(m_valid) + 2'(s_valid);
    bus.out_stall_cnt = cnt_q;
    in_fire   = bus.in_valid && bus.in_ready;
    out_fire  = bus.out_valid && bus.out_ready;
    clr       = bus.in_flush && ZERO_PAYLOAD;
    m_take_in = in_fire && (state_q == EMPTY || out_fire);
    s_take_in = in_fire && state_q == ONE && !out_fire;
    m_take_s  = out_fire && state_q == TWO;
    state_d   = bus.in_flush ? EMPTY :
                state_q == EMPTY ? (in_fire ? ONE : EMPTY) :
                state_q == ONE ? (s_take_in ? TWO : (out_fire && !in_fire) ? EMPTY : ONE) :
                (out_fire ? ONE : TWO);
    m_data_d  = clr ? '0 : m_take_in ? bus.in_data : m_take_s ? s_data_q : m_data_q;
    m_rob_d   = clr ? '0 : m_take_in ? bus.in_rob_idx : m_take_s ? s_rob_q : m_rob_q;
    s_data_d  = clr ? '0 : s_take_in ? bus.in_data : s_data_q;
    s_rob_d   = clr ? '0 : s_take_in ? bus.in_rob_idx : s_rob_q;
    cnt_d     = (m_valid && !bus.in_flush && (bus.in_stall || !bus.out_ready) && cnt_q != '1) ?
                cnt_q + CNT_W'(1) : cnt_q;
  end
  // state, payload and counter registers; reset acts immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= EMPTY;
      m_data_q <= '0;
      m_rob_q  <= '0;
      s_data_q <= '0;
      s_rob_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      m_data_q <= m_data_d;
      m_rob_q  <= m_rob_d;
      s_data_q <= s_data_d;
      s_rob_q  <= s_rob_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: directed checks of streaming, skid, flush, hold, async reset and counter saturation
module tb_pipe_stage_skid;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_cmp = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  pipe_stage_skid_if #(.DATA_W(128), .ROB_IDX_W(4), .CNT_W(16)) bus ();
  pipe_stage_skid_if #(.DATA_W(128), .ROB_IDX_W(4), .CNT_W(4)) b4 ();
  pipe_stage_skid #(.DATA_W(128), .ROB_IDX_W(4), .ZERO_PAYLOAD(1'b1), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  pipe_stage_skid #(.DATA_W(128), .ROB_IDX_W(4), .ZERO_PAYLOAD(1'b1), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .bus(b4)
  );
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic drv(input logic v, input logic [127:0] d, input logic [3:0] r,
                     input logic fl, input logic st, input logic ordy);
    @(negedge clk);
    bus.in_valid = v;
    bus.in_data = d;
    bus.in_rob_idx = r;
    bus.in_flush = fl;
    bus.in_stall = st;
    bus.out_ready = ordy;
    #1;
  endtask
  initial begin
    bus.in_valid = 0; bus.in_data = '0; bus.in_rob_idx = '0;
    bus.in_flush = 0; bus.in_stall = 0; bus.out_ready = 0;
    b4.in_valid = 0; b4.in_data = '0; b4.in_rob_idx = '0;
    b4.in_flush = 0; b4.in_stall = 0; b4.out_ready = 0;
    #2;
    chk("rst_out_valid", 128'(bus.out_valid), 128'd0);
    chk("rst_in_ready", 128'(bus.in_ready), 128'd0);
    chk("rst_occ", 128'(bus.out_occupancy), 128'd0);
    chk("rst_cnt", 128'(bus.out_stall_cnt), 128'd0);
    @(negedge clk);
    reset = 0;
    drv(1, 128'hA, 4'd1, 0, 0, 1);
    chk("s1_in_ready0", 128'(bus.in_ready), 128'd1);
    drv(1, 128'hB, 4'd2, 0, 0, 1);
    chk("s1_data_a", bus.out_data, 128'hA);
    chk("s1_rob_a", 128'(bus.out_rob_idx), 128'd1);
    chk("s1_occ_a", 128'(bus.out_occupancy), 128'd1);
    chk("s1_in_ready_a", 128'(bus.in_ready), 128'd1);
    drv(1, 128'hC, 4'd3, 0, 0, 1);
    chk("s1_data_b", bus.out_data, 128'hB);
    chk("s1_valid_b", 128'(bus.out_valid), 128'd1);
    chk("s1_in_ready_b", 128'(bus.in_ready), 128'd1);
    drv(0, 128'h0, 4'd0, 0, 0, 1);
    chk("s1_data_c", bus.out_data, 128'hC);
    chk("s1_occ_c", 128'(bus.out_occupancy), 128'd1);
    drv(1, 128'h11, 4'd4, 0, 0, 0);
    chk("s1_drained", 128'(bus.out_occupancy), 128'd0);
    chk("s1_cnt", 128'(bus.out_stall_cnt), 128'd0);
    drv(1, 128'h22, 4'd5, 0, 0, 0);
    chk("s2_occ1", 128'(bus.out_occupancy), 128'd1);
    chk("s2_head11", bus.out_data, 128'h11);
    drv(1, 128'h33, 4'd6, 0, 0, 0);
    chk("s2_occ2", 128'(bus.out_occupancy), 128'd2);
    chk("s2_in_ready0", 128'(bus.in_ready), 128'd0);
    chk("s2_head11b", bus.out_data, 128'h11);
    drv(1, 128'h33, 4'd6, 0, 0, 1);
    chk("s2_out11", bus.out_data, 128'h11);
    chk("s2_rob11", 128'(bus.out_rob_idx), 128'd4);
    chk("s2_cnt2", 128'(bus.out_stall_cnt), 128'd2);
    drv(1, 128'h33, 4'd6, 0, 0, 1);
    chk("s2_out22", bus.out_data, 128'h22);
    chk("s2_rob22", 128'(bus.out_rob_idx), 128'd5);
    chk("s2_occ_after", 128'(bus.out_occupancy), 128'd1);
    chk("s2_in_ready1", 128'(bus.in_ready), 128'd1);
    drv(0, 128'h0, 4'd0, 0, 0, 1);
    chk("s2_out33", bus.out_data, 128'h33);
    chk("s2_valid33", 128'(bus.out_valid), 128'd1);
    drv(1, 128'h55, 4'd7, 0, 0, 0);
    chk("s2_empty", 128'(bus.out_occupancy), 128'd0);
    chk("s2_cnt_end", 128'(bus.out_stall_cnt), 128'd2);
    drv(1, 128'h66, 4'd8, 0, 0, 0);
    drv(1, 128'h44, 4'd9, 1, 0, 0);
    chk("s3_occ2", 128'(bus.out_occupancy), 128'd2);
    chk("s3_in_ready0", 128'(bus.in_ready), 128'd0);
    chk("s3_out_valid0", 128'(bus.out_valid), 128'd0);
    drv(0, 128'h0, 4'd0, 0, 0, 1);
    chk("s3_occ0", 128'(bus.out_occupancy), 128'd0);
    chk("s3_valid0", 128'(bus.out_valid), 128'd0);
    chk("s3_data0", bus.out_data, 128'h0);
    chk("s3_rob0", 128'(bus.out_rob_idx), 128'd0);
    chk("s3_cnt3", 128'(bus.out_stall_cnt), 128'd3);
    drv(1, 128'h77, 4'd10, 0, 0, 1);
    chk("s3_no44", 128'(bus.out_valid), 128'd0);
    drv(0, 128'h0, 4'd0, 0, 1, 1);
    chk("s4_valid0", 128'(bus.out_valid), 128'd0);
    chk("s4_in_ready0", 128'(bus.in_ready), 128'd0);
    chk("s4_occ1", 128'(bus.out_occupancy), 128'd1);
    drv(0, 128'h0, 4'd0, 0, 1, 1);
    chk("s4_hold1", 128'(bus.out_occupancy), 128'd1);
    drv(0, 128'h0, 4'd0, 0, 1, 1);
    chk("s4_hold2", bus.out_data, 128'h77);
    drv(0, 128'h0, 4'd0, 0, 0, 1);
    chk("s4_cnt6", 128'(bus.out_stall_cnt), 128'd6);
    chk("s4_valid1", 128'(bus.out_valid), 128'd1);
    chk("s4_data77", bus.out_data, 128'h77);
    drv(1, 128'h88, 4'd11, 0, 0, 0);
    chk("s4_emitted", 128'(bus.out_occupancy), 128'd0);
    drv(1, 128'h99, 4'd12, 0, 0, 0);
    drv(0, 128'h0, 4'd0, 0, 0, 0);
    chk("s5_occ2", 128'(bus.out_occupancy), 128'd2);
    chk("s5_cnt7", 128'(bus.out_stall_cnt), 128'd7);
    #1 reset = 1;
    #1;
    chk("s5_valid0", 128'(bus.out_valid), 128'd0);
    chk("s5_occ0", 128'(bus.out_occupancy), 128'd0);
    chk("s5_cnt0", 128'(bus.out_stall_cnt), 128'd0);
    chk("s5_data0", bus.out_data, 128'h0);
    chk("s5_in_ready0", 128'(bus.in_ready), 128'd0);
    #1 reset = 0;
    drv(0, 128'h0, 4'd0, 0, 0, 0);
    chk("s5_after_occ", 128'(bus.out_occupancy), 128'd0);
    chk("s5_after_valid", 128'(bus.out_valid), 128'd0);
    @(negedge clk);
    b4.in_valid = 1; b4.in_data = 128'h5; b4.in_rob_idx = 4'd3; b4.out_ready = 0;
    for (int i = 1; i <= 21; i++) begin
      @(negedge clk);
      b4.in_valid = 0;
      #1;
      if (i == 15) chk("s6_cnt14", 128'(b4.out_stall_cnt), 128'd14);
    end
    chk("s6_cnt_sat", 128'(b4.out_stall_cnt), 128'd15);
    chk("s6_occ1", 128'(b4.out_occupancy), 128'd1);
    chk("s6_data", b4.out_data, 128'h5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
